byte_unstriping_nlane: RTL and testbench

Parametrised N-lane byte un-striper. Each lane feeds its own small deskew FIFO. A round-robin reassembly FSM merges the lane streams back into one serial word stream. It sits on the receive side of the PHY-lite path after the per-lane deserialisers, and it handles inter-lane skew, lane-count mode and stalls.

---
 rtl/byte_unstriping_pkg.sv | 21 ++
 rtl/lane_fifo.sv | 58 +++++
 rtl/byte_unstriping_nlane.sv | 168 ++++++++++++++++
 tb/tb_byte_unstriping_nlane.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_unstriping_pkg.sv
// Shared types and helpers for the N-lane byte un-striper.
// One-hot FSM encoding and lane-count clamping.
package byte_unstriping_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      ALIGN  = 4'b0010,
      STREAM = 4'b0100,
      FLUSH  = 4'b1000
   } state_e;

   // Requested lane count of 0 or above the physical count means "all".
   function automatic int unsigned clamp_lanes(
      input int unsigned req,
      input int unsigned lanes
   );
      if (req == 0 || req > lanes) return lanes;
      return req;
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane deskew FIFO, show-ahead read, synchronous flush.
// A push into a full FIFO is taken only if it pops in the same cycle.
module lane_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] P_ONE = AW'(1);
   localparam logic [AW:0]   C_ONE = (AW+1)'(1);
   localparam logic [AW:0]   C_MAX = (AW+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_q;
   logic [AW-1:0]     rd_q;
   logic [AW:0]       cnt_q;
   logic              do_push;
   logic              do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == C_MAX);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_q];

   // Storage write; no reset needed, occupancy gates what is visible.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem_q[wr_q] <= din;
   end

   // Read/write pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + P_ONE;
         if (do_pop)  rd_q <= rd_q + P_ONE;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + C_ONE;
            2'b01:   cnt_q <= cnt_q - C_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/byte_unstriping_nlane.sv
// N-lane byte un-striper: per-lane deskew FIFOs merged back
// into one serial stream by a round-robin reassembly FSM.
module byte_unstriping_nlane
   import byte_unstriping_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int STALL_MAX  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [LANES*DATA_W-1:0]    lane_data,
   input  logic [LANES-1:0]           lane_valid,
   input  logic [$clog2(LANES+1)-1:0] active_lanes,
   output logic [DATA_W-1:0]          data_out,
   output logic                       valid_out,
   output logic                       err_overflow,
   output logic                       err_timeout
);

   localparam int LW = $clog2(LANES+1);
   localparam int PW = $clog2(LANES);
   localparam int SW = $clog2(STALL_MAX+1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [LW-1:0] L_ONE  = LW'(1);
   localparam logic [SW-1:0] S_ONE  = SW'(1);
   localparam logic [SW-1:0] S_LAST = SW'(STALL_MAX-1);
   localparam logic [LANES-1:0] ONEHOT0 = LANES'(1);

   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [SW-1:0]     stall_q, stall_d;
   logic [LW-1:0]     lanes_q, lanes_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              vout_q, vout_d;
   logic              eovf_q, eovf_d;
   logic              eto_q, eto_d;

   logic [DATA_W-1:0] f_dout [LANES];
   logic [LANES-1:0]  f_empty;
   logic [LANES-1:0]  f_full;
   logic [LANES-1:0]  act;
   logic [LANES-1:0]  push_vec;
   logic [LANES-1:0]  pop_vec;
   logic              flush;
   logic              all_ne;
   logic              any_ne;
   logic              head_empty;
   logic              pop_en;
   logic              ovf_hit;

   assign flush      = (state_q == FLUSH);
   assign all_ne     = &(~f_empty | ~act);
   assign any_ne     = |(~f_empty & act);
   assign head_empty = f_empty[ptr_q];
   assign pop_en     = (state_q == STREAM) & ~head_empty;
   assign pop_vec    = pop_en ? (ONEHOT0 << ptr_q) : '0;
   assign ovf_hit    = |(push_vec & f_full & ~pop_vec);
   assign eovf_d     = eovf_q | ovf_hit;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign act[i]      = (LW'(i) < lanes_q);
      assign push_vec[i] = lane_valid[i] & act[i] & ~flush;

      lane_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push_vec[i]),
         .pop   (pop_vec[i]),
         .flush (flush),
         .din   (lane_data[i*DATA_W +: DATA_W]),
         .dout  (f_dout[i]),
         .empty (f_empty[i]),
         .full  (f_full[i])
      );
   end

   // Reassembly FSM: next state, pointer, stall timer and output word.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      stall_d = stall_q;
      lanes_d = lanes_q;
      dout_d  = '0;
      vout_d  = 1'b0;
      eto_d   = eto_q;
      unique case (state_q)
         IDLE: begin
            lanes_d = LW'(clamp_lanes(32'(active_lanes), LANES));
            if (all_ne) begin
               state_d = STREAM;
               ptr_d   = '0;
               stall_d = '0;
            end else if (any_ne) begin
               state_d = ALIGN;
               stall_d = '0;
            end
         end
         ALIGN: begin
            if (all_ne) begin
               state_d = STREAM;
               ptr_d   = '0;
               stall_d = '0;
            end else if (stall_q == S_LAST) begin
               eto_d   = 1'b1;
               state_d = FLUSH;
            end else begin
               stall_d = stall_q + S_ONE;
            end
         end
         STREAM: begin
            if (!head_empty) begin
               dout_d  = f_dout[ptr_q];
               vout_d  = 1'b1;
               stall_d = '0;
               if (LW'(ptr_q) == lanes_q - L_ONE) ptr_d = '0;
               else                              ptr_d = ptr_q + P_ONE;
            end else if (ptr_q == '0) begin
               state_d = IDLE;
            end else if (stall_q == S_LAST) begin
               eto_d   = 1'b1;
               state_d = FLUSH;
            end else begin
               stall_d = stall_q + S_ONE;
            end
         end
         FLUSH: begin
            ptr_d   = '0;
            stall_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, control and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         stall_q <= '0;
         lanes_q <= LW'(LANES);
         dout_q  <= '0;
         vout_q  <= 1'b0;
         eovf_q  <= 1'b0;
         eto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         stall_q <= stall_d;
         lanes_q <= lanes_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         eovf_q  <= eovf_d;
         eto_q   <= eto_d;
      end
   end

   assign data_out     = dout_q;
   assign valid_out    = vout_q;
   assign err_overflow = eovf_q;
   assign err_timeout  = eto_q;

endmodule

// File: tb/tb_byte_unstriping_nlane.sv
// Directed bench for the 4-lane byte un-striper.
// Expected words and flags are hand-derived per edge.
module tb_byte_unstriping_nlane;

   logic        clk;
   logic        reset;
   logic [31:0] lane_data;
   logic [3:0]  lane_valid;
   logic [2:0]  active_lanes;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        err_overflow;
   logic        err_timeout;

   int n_chk;
   int n_fail;

   byte_unstriping_nlane #(
      .DATA_W     (8),
      .LANES      (4),
      .FIFO_DEPTH (4),
      .STALL_MAX  (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lane_data    (lane_data),
      .lane_valid   (lane_valid),
      .active_lanes (active_lanes),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] m, input logic [7:0] b);
      lane_valid = m;
      for (int i = 0; i < 4; i++) lane_data[i*8 +: 8] = b + 8'(i);
   endtask

   task automatic quiet();
      lane_valid = '0;
   endtask

   task automatic exp_word(input string tag, input logic [7:0] w);
      tick();
      check({tag, "_v"}, 32'(valid_out), 32'd1);
      check({tag, "_d"}, 32'(data_out), 32'(w));
   endtask

   task automatic exp_none(input string tag);
      tick();
      check({tag, "_v"}, 32'(valid_out), 32'd0);
      check({tag, "_d"}, 32'(data_out), 32'd0);
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      clk = 1'b0;
      reset = 1'b1;
      lane_valid = '0;
      lane_data = '0;
      active_lanes = 3'd4;
      tick();
      tick();
      check("rst_v", 32'(valid_out), 32'd0);
      check("rst_d", 32'(data_out), 32'd0);
      check("rst_ovf", 32'(err_overflow), 32'd0);
      check("rst_to", 32'(err_timeout), 32'd0);
      reset = 1'b0;
      tick();

      // Aligned groups A and B, back to back.
      drive(4'hF, 8'hA0);
      tick();
      quiet();
      exp_none("al_e1");
      exp_word("al_a0", 8'hA0);
      exp_word("al_a1", 8'hA1);
      drive(4'hF, 8'hB0);
      exp_word("al_a2", 8'hA2);
      quiet();
      exp_word("al_a3", 8'hA3);
      exp_word("al_b0", 8'hB0);
      exp_word("al_b1", 8'hB1);
      exp_word("al_b2", 8'hB2);
      exp_word("al_b3", 8'hB3);
      exp_none("al_end");
      tick();

      // Lane 3 two cycles late.
      drive(4'h7, 8'h10);
      tick();
      quiet();
      tick();
      drive(4'h8, 8'h10);
      exp_none("sk_al1");
      quiet();
      exp_none("sk_al2");
      exp_word("sk_0", 8'h10);
      exp_word("sk_1", 8'h11);
      exp_word("sk_2", 8'h12);
      exp_word("sk_3", 8'h13);
      exp_none("sk_end");
      check("sk_ovf", 32'(err_overflow), 32'd0);
      check("sk_to", 32'(err_timeout), 32'd0);

      // Two-lane mode; lanes 2-3 carry junk that must be ignored.
      active_lanes = 3'd2;
      tick();
      tick();
      drive(4'hF, 8'h20);
      tick();
      drive(4'hF, 8'h30);
      exp_none("l2_e1");
      quiet();
      exp_word("l2_g0a", 8'h20);
      exp_word("l2_g0b", 8'h21);
      exp_word("l2_g1a", 8'h30);
      exp_word("l2_g1b", 8'h31);
      exp_none("l2_end");
      for (int k = 0; k < 5; k++) begin
         drive(4'hC, 8'h40 + 8'(k));
         tick();
      end
      quiet();
      check("l2_junk_v", 32'(valid_out), 32'd0);
      check("l2_ovf", 32'(err_overflow), 32'd0);
      active_lanes = 3'd0;
      tick();
      tick();

      // Full group then half group; stall times out, flush, recover.
      drive(4'hF, 8'h50);
      tick();
      quiet();
      exp_none("pg_e1");
      exp_word("pg_50", 8'h50);
      exp_word("pg_51", 8'h51);
      drive(4'h3, 8'h60);
      exp_word("pg_52", 8'h52);
      quiet();
      exp_word("pg_53", 8'h53);
      exp_word("pg_60", 8'h60);
      exp_word("pg_61", 8'h61);
      for (int k = 0; k < 7; k++) begin
         tick();
         check("pg_stall_to", 32'(err_timeout), 32'd0);
         check("pg_stall_v", 32'(valid_out), 32'd0);
      end
      tick();
      check("pg_to_set", 32'(err_timeout), 32'd1);
      drive(4'hF, 8'hE0);
      tick();
      check("pg_flush_v", 32'(valid_out), 32'd0);
      drive(4'hF, 8'h70);
      tick();
      quiet();
      exp_none("pg_r_e1");
      exp_word("pg_70", 8'h70);
      exp_word("pg_71", 8'h71);
      exp_word("pg_72", 8'h72);
      exp_word("pg_73", 8'h73);
      exp_none("pg_r_end");
      check("pg_to_sticky", 32'(err_timeout), 32'd1);

      // Five pushes on lane 1 only; the fifth overflows.
      drive(4'h2, 8'h80);
      tick();
      drive(4'h2, 8'h90);
      tick();
      drive(4'h2, 8'hA0);
      tick();
      drive(4'h2, 8'hB0);
      tick();
      check("ov_pre", 32'(err_overflow), 32'd0);
      drive(4'h2, 8'hC0);
      tick();
      check("ov_set", 32'(err_overflow), 32'd1);
      drive(4'hD, 8'hD0);
      tick();
      quiet();
      exp_none("ov_e6");
      exp_word("ov_d0", 8'hD0);
      exp_word("ov_81", 8'h81);
      exp_word("ov_d2", 8'hD2);
      exp_word("ov_d3", 8'hD3);
      exp_none("ov_end");

      // Reset in the middle of streaming.
      drive(4'hF, 8'hF0);
      tick();
      quiet();
      tick();
      exp_word("rs_f0", 8'hF0);
      reset = 1'b1;
      tick();
      check("rs_v", 32'(valid_out), 32'd0);
      check("rs_d", 32'(data_out), 32'd0);
      check("rs_ovf", 32'(err_overflow), 32'd0);
      check("rs_to", 32'(err_timeout), 32'd0);
      reset = 1'b0;
      tick();
      drive(4'hF, 8'hC0);
      tick();
      quiet();
      exp_none("rs_e1");
      exp_word("rs_c0", 8'hC0);
      exp_word("rs_c1", 8'hC1);
      exp_word("rs_c2", 8'hC2);
      exp_word("rs_c3", 8'hC3);
      exp_none("rs_end");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
